add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_sequencer.sv | 144 ++++++++++++++
 tb/tb_add_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/add_sequencer.sv
// Multi-cycle W-bit add/subtract built from one N-bit chunk adder.
// The operation runs one chunk per clock, LSB chunk first. The visible
// result and flags update together in a single DONE cycle. Intermediate
// sums are never shown on c.

// One N-bit slice: x + (y ^ {N{inv}}) + cin, with the carry out exposed.
module add_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         inv,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] sum;

    // Widen by one bit so the chunk carry-out falls out of the add.
    assign sum  = {1'b0, x} + {1'b0, y ^ {N{inv}}} + {{N{1'b0}}, cin};
    assign s    = sum[N-1:0];
    assign cout = sum[N];
endmodule

module add_sequencer #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic [N*WORDS-1:0]   c,
    output logic [3:0]           banderas,
    output logic                 busy,
    output logic                 done
);
    localparam int W  = N * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation captured at start and frozen until the result is published.
    typedef struct packed {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    state_t        state;
    req_t          cur;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  res;

    logic [N-1:0]  ak;
    logic [N-1:0]  bk;
    logic [N-1:0]  sk;
    logic          ck;

    logic [W-1:0]  bx;
    logic          nf;
    logic          zf;
    logic          vf;

    // The current chunk of each captured operand feeds the single slice adder.
    assign ak = cur.a[k*N +: N];
    assign bk = cur.b[k*N +: N];

    add_chunk #(.N(N)) u_chunk (
        .x    (ak),
        .y    (bk),
        .inv  (cur.op),
        .cin  (carry),
        .s    (sk),
        .cout (ck)
    );

    // Flags come from the completed result held in res during DONE.
    // V compares the sign of a with the sign of b as it was actually added.
    // That is b inverted for subtract.
    assign bx = cur.b ^ {W{cur.op}};
    assign nf = res[W-1];
    assign zf = (res == '0);
    assign vf = (cur.a[W-1] == bx[W-1]) && (res[W-1] != cur.a[W-1]);

    // Sequencer: capture in IDLE, one chunk per RUN cycle, publish in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            k        <= '0;
            carry    <= 1'b0;
            res      <= '0;
            c        <= '0;
            banderas <= 4'b0000;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // A start seen while done is still high is dropped.
                    // The next accept therefore comes one IDLE cycle later.
                    if (start && !done) begin
                        cur   <= '{op: op, a: a, b: b};
                        k     <= '0;
                        carry <= op;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[k*N +: N] <= sk;
                    carry         <= ck;
                    k             <= k + KW'(1);
                    if (k == KLAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    c        <= res;
                    banderas <= {nf, zf, carry, vf};
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer (N=4, WORDS=4).
// Expected results go into a queue at issue time. A monitor pops and
// compares them on every done pulse.
module tb_add_sequencer;
    localparam int N = 4;
    localparam int WORDS = 4;
    localparam int W = N * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [3:0]   banderas;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [W-1:0] c;
        logic [3:0]   f;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .c        (c),
        .banderas (banderas),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_c", 32'(c), 32'(e.c));
                chk("result_flags", 32'(banderas), 32'(e.f));
            end
        end
    end

    // Issue one operation. Check done latency (6) and busy length (5).
    task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ec, input logic [3:0] ef);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back('{c: ec, f: ef});
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'd6);
        chk("busy_cycles", 32'(bcnt), 32'd5);
        @(negedge clk);
    endtask

    initial begin
        int dcnt;
        int dcyc[3];
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_c", 32'(c), 32'd0);
        chk("reset_flags", 32'(banderas), 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000);
        do_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
        do_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
        do_op(1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b0111);
        do_op(1'b1, 16'h0005, 16'h0005, 16'h0000, 4'b0110);
        do_op(1'b1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
        do_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);

        // Second start pulsed during RUN must be ignored entirely.
        dcnt = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h0010; b = 16'h0020;
        exp_q.push_back('{c: 16'h0030, f: 4'b0000});
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) begin
                start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'h0001;
            end
            if (cyc == 3) start = 1'b0;
            if (done) dcnt++;
        end
        chk("midrun_done_count", 32'(dcnt), 32'd1);

        // Start held high: back-to-back operations, one done every 7 cycles.
        dcnt = 0;
        dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0002;
        repeat (3) exp_q.push_back('{c: 16'h0003, f: 4'b0000});
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                dcyc[dcnt] = cyc;
                dcnt++;
                if (dcnt == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(dcnt), 32'd3);
        chk("b2b_first", 32'(dcyc[0]), 32'd6);
        chk("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd7);
        chk("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd7);
        repeat (2) @(negedge clk);

        // Reset in the second RUN cycle aborts the operation without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_c", 32'(c), 32'd0);
        chk("abort_flags", 32'(banderas), 32'd0);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);

        do_op(1'b0, 16'h1234, 16'h1111, 16'h2345, 4'b0000);

        // Idle for 20 cycles: outputs hold and no activity appears.
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            chk("idle_hold", {10'd0, c, banderas, done, busy}, {10'd0, 16'h2345, 4'b0000, 1'b0, 1'b0});
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
